// File: rtl/bpred_pkg.sv
// Shared helpers for the gshare branch predictor: counter reset value,
// saturating counter step and the PC/history index hash.
package bpred_pkg;

    localparam int CTR_MAX_W = 4;

    function automatic logic [CTR_MAX_W-1:0] ctr_reset_val(int w);
        return CTR_MAX_W'(1 << (w - 1));
    endfunction

    function automatic logic [CTR_MAX_W-1:0] ctr_sat_step(logic [CTR_MAX_W-1:0] c,
                                                          logic up, int w);
        logic [CTR_MAX_W-1:0] top_v;
        top_v = CTR_MAX_W'((1 << w) - 1);
        if (up)
            return (c == top_v) ? c : c + 1'b1;
        else
            return (c == '0) ? c : c - 1'b1;
    endfunction

    // Word-aligned PC bits folded with history; caller truncates to its index width.
    function automatic logic [31:0] idx_hash(logic [63:0] pc, logic [31:0] ghr);
        return 32'(pc >> 2) ^ ghr;
    endfunction

endpackage

// File: rtl/bpred_ghr.sv
// Global history register: speculative shift on lookup, checkpoint recovery
// on mispredict (recovery has priority over a same-cycle shift).
module bpred_ghr #(
    parameter int GHR_WIDTH = 10
) (
    input  logic                 i_Clk,
    input  logic                 i_Reset_n,
    input  logic                 shift_en,
    input  logic                 shift_bit,
    input  logic                 recover_en,
    input  logic [GHR_WIDTH-1:0] recover_ghr,
    input  logic                 recover_bit,
    output logic [GHR_WIDTH-1:0] ghr
);

    // Truncating the concatenation drops the oldest bit and also covers GHR_WIDTH == 1.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n)
            ghr <= '0;
        else if (recover_en)
            ghr <= GHR_WIDTH'({recover_ghr, recover_bit});
        else if (shift_en)
            ghr <= GHR_WIDTH'({ghr, shift_bit});
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare direction predictor: PC xor GHR indexed table of saturating counters
// with same-cycle update bypass. Optional statistics under BPRED_STATS_EN.
module gshare_predictor
    import bpred_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INDEX_WIDTH = 10,
    parameter int GHR_WIDTH   = 10,
    parameter int CTR_WIDTH   = 2
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_Lookup_Valid,
    input  logic [PC_WIDTH-1:0]    i_Lookup_PC,
    output logic                   o_Prediction,
    output logic [INDEX_WIDTH-1:0] o_Pred_Index,
    output logic [GHR_WIDTH-1:0]   o_Pred_GHR,
    input  logic                   i_Resolve_Valid,
    input  logic [INDEX_WIDTH-1:0] i_Resolve_Index,
    input  logic                   i_Resolve_Outcome,
    input  logic                   i_Resolve_Mispredict,
    input  logic [GHR_WIDTH-1:0]   i_Resolve_GHR,
    output logic [31:0]            o_Stat_Branches,
    output logic [31:0]            o_Stat_Mispredicts
);

    localparam int DEPTH = 1 << INDEX_WIDTH;

    if (GHR_WIDTH < 1 || GHR_WIDTH > INDEX_WIDTH) begin : g_bad_ghr
        $error("gshare_predictor: GHR_WIDTH must lie in 1..INDEX_WIDTH");
    end
    if (CTR_WIDTH < 1 || CTR_WIDTH > CTR_MAX_W) begin : g_bad_ctr
        $error("gshare_predictor: CTR_WIDTH must lie in 1..4");
    end

    logic [GHR_WIDTH-1:0]   ghr;
    logic [INDEX_WIDTH-1:0] lookup_idx;
    logic [CTR_WIDTH-1:0]   ctr_tbl [DEPTH];
    logic [CTR_WIDTH-1:0]   res_next;
    logic                   bypass;
    logic                   recover;

    assign lookup_idx = INDEX_WIDTH'(idx_hash(64'(i_Lookup_PC), 32'(ghr)));
    assign res_next   = CTR_WIDTH'(ctr_sat_step(CTR_MAX_W'(ctr_tbl[i_Resolve_Index]),
                                                i_Resolve_Outcome, CTR_WIDTH));
    assign bypass     = i_Resolve_Valid && (i_Resolve_Index == lookup_idx);

    // A same-cycle update to the looked-up entry is forwarded before it is written.
    assign o_Prediction = bypass ? res_next[CTR_WIDTH-1]
                                 : ctr_tbl[lookup_idx][CTR_WIDTH-1];
    assign o_Pred_Index = lookup_idx;
    assign o_Pred_GHR   = ghr;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                ctr_tbl[i] <= CTR_WIDTH'(ctr_reset_val(CTR_WIDTH));
        end else if (i_Resolve_Valid) begin
            ctr_tbl[i_Resolve_Index] <= res_next;
        end
    end

    assign recover = i_Resolve_Valid && i_Resolve_Mispredict;

    bpred_ghr #(
        .GHR_WIDTH (GHR_WIDTH)
    ) u_ghr (
        .i_Clk       (i_Clk),
        .i_Reset_n   (i_Reset_n),
        .shift_en    (i_Lookup_Valid),
        .shift_bit   (o_Prediction),
        .recover_en  (recover),
        .recover_ghr (i_Resolve_GHR),
        .recover_bit (i_Resolve_Outcome),
        .ghr         (ghr)
    );

`ifdef BPRED_STATS_EN
    logic [31:0] stat_br;
    logic [31:0] stat_mp;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            stat_br <= '0;
            stat_mp <= '0;
        end else if (i_Resolve_Valid) begin
            if (stat_br != '1)
                stat_br <= stat_br + 32'd1;
            if (i_Resolve_Mispredict && stat_mp != '1)
                stat_mp <= stat_mp + 32'd1;
        end
    end

    assign o_Stat_Branches    = stat_br;
    assign o_Stat_Mispredicts = stat_mp;
`else
    assign o_Stat_Branches    = '0;
    assign o_Stat_Mispredicts = '0;
`endif

endmodule

// File: tb/tb_gshare_predictor.sv
// Self-checking bench for gshare_predictor: directed scenarios followed by
// randomized traffic against a table/array reference model.
module tb_gshare_predictor;

    localparam int PCW   = 32;
    localparam int IW    = 10;
    localparam int GW    = 10;
    localparam int CW    = 2;
    localparam int DEPTH = 1 << IW;
    localparam int IMASK = DEPTH - 1;
    localparam int GMASK = (1 << GW) - 1;
    localparam int CMAX  = (1 << CW) - 1;

    logic           clk;
    logic           rst_n;
    logic           lv;
    logic [PCW-1:0] lpc;
    logic           pred;
    logic [IW-1:0]  pidx;
    logic [GW-1:0]  pghr;
    logic           rv;
    logic [IW-1:0]  ridx;
    logic           rout;
    logic           rmp;
    logic [GW-1:0]  rghr;
    logic [31:0]    st_br;
    logic [31:0]    st_mp;

    gshare_predictor #(
        .PC_WIDTH    (PCW),
        .INDEX_WIDTH (IW),
        .GHR_WIDTH   (GW),
        .CTR_WIDTH   (CW)
    ) dut (
        .i_Clk                (clk),
        .i_Reset_n            (rst_n),
        .i_Lookup_Valid       (lv),
        .i_Lookup_PC          (lpc),
        .o_Prediction         (pred),
        .o_Pred_Index         (pidx),
        .o_Pred_GHR           (pghr),
        .i_Resolve_Valid      (rv),
        .i_Resolve_Index      (ridx),
        .i_Resolve_Outcome    (rout),
        .i_Resolve_Mispredict (rmp),
        .i_Resolve_GHR        (rghr),
        .o_Stat_Branches      (st_br),
        .o_Stat_Mispredicts   (st_mp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          m_ctr [DEPTH];
    int          m_ghr;
    int unsigned m_br;
    int unsigned m_mp;
    int          n_checks;
    int          n_err;
    logic        last_pred;
    logic [31:0] last_ghr;
    logic [31:0] last_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int sat(int c, bit up);
        if (up) return (c >= CMAX) ? CMAX : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction

    function automatic int model_idx(logic [31:0] pc);
        return ((int'(pc >> 2)) ^ m_ghr) & IMASK;
    endfunction

    function automatic logic [31:0] pc_for(int idx);
        return 32'(((idx ^ m_ghr) & IMASK) << 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_ctr[i] = 1 << (CW - 1);
        m_ghr = 0;
        m_br  = 0;
        m_mp  = 0;
    endtask

    // Starts and ends 1 time unit after a rising edge; checks sit mid-cycle.
    task automatic cycle();
        int idx;
        int c;
        int p;
        #2;
        idx = model_idx(lpc);
        c   = m_ctr[idx];
        if (rv && int'(ridx) == idx) c = sat(c, rout);
        p = (c >> (CW - 1)) & 1;
        if (lv) begin
            chk("pred",  32'(pred), 32'(p));
            chk("index", 32'(pidx), 32'(idx));
            chk("pghr",  32'(pghr), 32'(m_ghr));
            last_pred = pred;
            last_ghr  = 32'(pghr);
            last_idx  = 32'(pidx);
        end
`ifdef BPRED_STATS_EN
        chk("stat_br", st_br, m_br);
        chk("stat_mp", st_mp, m_mp);
`else
        chk("stat_br_off", st_br, 32'd0);
        chk("stat_mp_off", st_mp, 32'd0);
`endif
        @(posedge clk);
        if (rv) begin
            m_ctr[ridx] = sat(m_ctr[ridx], rout);
            if (m_br != 32'hFFFF_FFFF) m_br++;
            if (rmp && m_mp != 32'hFFFF_FFFF) m_mp++;
        end
        if (rv && rmp)
            m_ghr = ((int'(rghr) << 1) | int'(rout)) & GMASK;
        else if (lv)
            m_ghr = ((m_ghr << 1) | p) & GMASK;
        #1;
    endtask

    task automatic step(input bit lv_, input logic [31:0] pc_, input bit rv_, input int ridx_,
                        input bit out_, input bit mp_, input int rghr_);
        lv   = lv_;
        lpc  = pc_;
        rv   = rv_;
        ridx = IW'(ridx_);
        rout = out_;
        rmp  = mp_;
        rghr = GW'(rghr_);
        cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        lv = 1'b0; lpc = '0; rv = 1'b0; ridx = '0; rout = 1'b0; rmp = 1'b0; rghr = '0;
        #2;
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n = 1'b0;
        lv = 1'b0; lpc = '0; rv = 1'b0; ridx = '0; rout = 1'b0; rmp = 1'b0; rghr = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state lookup
        step(1, 32'h0000_0400, 0, 0, 0, 0, 0);
        chk("rst_idx",  last_idx, 32'h100);
        chk("rst_ghr",  last_ghr, 32'h0);
        chk("rst_pred", 32'(last_pred), 32'd1);

        // Saturation at index 5
        do_reset();
        repeat (3) step(0, 32'h0, 1, 5, 1, 0, 0);
        step(1, pc_for(5), 0, 0, 0, 0, 0);
        chk("sat_hi_pred", 32'(last_pred), 32'd1);
        step(0, 32'h0, 1, 5, 0, 0, 0);
        step(1, pc_for(5), 0, 0, 0, 0, 0);
        chk("sat_2_pred", 32'(last_pred), 32'd1);
        step(0, 32'h0, 1, 5, 0, 0, 0);
        step(1, pc_for(5), 0, 0, 0, 0, 0);
        chk("sat_1_pred", 32'(last_pred), 32'd0);
        repeat (4) step(0, 32'h0, 1, 5, 0, 0, 0);
        step(0, 32'h0, 1, 5, 1, 0, 0);
        step(1, pc_for(5), 0, 0, 0, 0, 0);
        chk("sat_lo_hold", 32'(last_pred), 32'd0);

        // Speculative history
        do_reset();
        step(1, 32'h0000_1000, 0, 0, 0, 0, 0);
        chk("spec_p0", 32'(last_pred), 32'd1);
        step(1, 32'h0000_2000, 0, 0, 0, 0, 0);
        chk("spec_p1", 32'(last_pred), 32'd1);
        step(1, 32'h0000_3000, 0, 0, 0, 0, 0);
        chk("spec_p2", 32'(last_pred), 32'd1);
        step(1, 32'h0000_4000, 0, 0, 0, 0, 0);
        chk("spec_ghr", last_ghr, 32'h007);

        // Recovery colliding with a lookup
        step(1, 32'h0000_0040, 1, 3, 0, 1, 'h00A);
        step(1, 32'h0000_0080, 0, 0, 0, 0, 0);
        chk("recov_ghr", last_ghr, 32'h014);

        // Bypass
        do_reset();
        step(0, 32'h0, 1, 5, 0, 0, 0);
        step(1, pc_for(5), 1, 5, 1, 0, 0);
        chk("bypass_pred", 32'(last_pred), 32'd1);

        // Stats, then asynchronous reset mid-run
        do_reset();
        step(0, 32'h0, 1, 10, 1, 0, 0);
        step(0, 32'h0, 1, 11, 0, 1, 'h3);
        step(0, 32'h0, 1, 12, 1, 0, 0);
        step(0, 32'h0, 1, 13, 0, 0, 0);
        step(0, 32'h0, 0, 0, 0, 0, 0);
`ifdef BPRED_STATS_EN
        chk("stats_br4", st_br, 32'd4);
        chk("stats_mp1", st_mp, 32'd1);
`else
        chk("stats_br_zero", st_br, 32'd0);
        chk("stats_mp_zero", st_mp, 32'd0);
`endif
        lv = 1'b1; lpc = 32'h0; rv = 1'b1; ridx = IW'(7); rout = 1'b0; rmp = 1'b1; rghr = GW'(5);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_br",  st_br, 32'd0);
        chk("arst_mp",  st_mp, 32'd0);
        chk("arst_ghr", 32'(pghr), 32'd0);
        @(posedge clk);
        model_reset();
        #1;
        rst_n = 1'b1;
        rv = 1'b0;
        step(1, pc_for(7), 0, 0, 0, 0, 0);
        chk("arst_no_update", 32'(last_pred), 32'd1);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] pc;
            int          ri;
            pc = ($urandom % 2 == 0) ? 32'($urandom_range(0, 63) << 2) : $urandom;
            ri = ($urandom % 3 == 0) ? model_idx(pc) : int'($urandom_range(0, 63));
            step($urandom % 4 != 0, pc, $urandom % 2 == 0, ri, $urandom % 2 == 1,
                 $urandom % 8 == 0, int'($urandom & GMASK));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
